// File: rtl/memoria_responder.sv
// memoria_responder: word-organised memory that answers one read/write request at a
// time after a fixed number of wait states. Misaligned or out-of-range accesses are
// reported through err and never touch storage.
module memoria_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        MemReadWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy,
  output logic [1:0]  State_out
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            cap_we_q;
  logic [31:0]     cap_addr_q;
  logic [31:0]     cap_wdata_q;
  logic [31:0]     rdata_q;
  logic            ack_q;
  logic            err_q;
  logic            busy_q;

  // Storage is not touched by reset; it powers up cleared.
  logic [31:0]     mem_q [DEPTH] = '{default: '0};

  logic            resp_entry_d;
  logic            addr_err_d;
  logic [AW-1:0]   word_idx_d;
  logic            mem_we_d;

  // Decode of the captured request, evaluated on the edge that enters RESP.
  always_comb begin
    resp_entry_d = (state_q == ST_WAIT) && (cnt_q == '0);
    addr_err_d   = (cap_addr_q[1:0] != 2'b00) || (cap_addr_q[31:2] >= 30'(DEPTH));
    word_idx_d   = cap_addr_q[AW+1:2];
    // Reset aborts the commit even on the edge that would have entered RESP.
    mem_we_d     = resp_entry_d && cap_we_q && !addr_err_d && !reset;
  end

  // Request sequencer: capture in IDLE, count wait states, one-cycle response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (req) begin
            cap_we_q    <= MemReadWrite;
            cap_addr_q  <= addr;
            cap_wdata_q <= wdata;
            cnt_q       <= CW'(WAIT_CYCLES - 1);
            state_q     <= ST_WAIT;
            busy_q      <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_RESP;
            ack_q   <= 1'b1;
            err_q   <= addr_err_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          // A request seen here is dropped, not queued: back-to-back accepts
          // therefore land WAIT_CYCLES+2 edges apart.
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage port: write commit and registered read, both on RESP entry.
  always_ff @(posedge clock) begin
    if (mem_we_d) begin
      mem_q[word_idx_d] <= cap_wdata_q;
    end
    if (reset) begin
      rdata_q <= '0;
    end else if (resp_entry_d) begin
      if (addr_err_d) begin
        rdata_q <= '0;
      end else if (!cap_we_q) begin
        rdata_q <= mem_q[word_idx_d];
      end
    end
  end

  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign busy      = busy_q;
  // The unused encoding reports as IDLE.
  assign State_out = (state_q == ST_WAIT || state_q == ST_RESP) ? state_q : ST_IDLE;

endmodule
